// File: rtl/fa_response_checker.sv
// Drives all eight {a,b,c} vectors into a 1-bit full adder and checks sum/carry against the ideal result.
// Each vector takes SETTLE_CYCLES+1 clocks; done rises 8*(SETTLE_CYCLES+1)+1 clocks after start is sampled.
module fa_response_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       sum_in,
  input  logic       carry_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  // With no settle time a freshly driven vector is checked on the very next clock.
  localparam state_t AFTER_DRIVE = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

  state_t        state, state_d;
  logic [2:0]    vec, vec_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          busy_d, done_d, pass_d;
  logic [3:0]    err_d;
  logic [2:0]    first_d;
  logic          exp_sum, exp_carry, mismatch, launch;

  assign a = vec[2];
  assign b = vec[1];
  assign c = vec[0];

  assign exp_sum   = vec[2] ^ vec[1] ^ vec[0];
  assign exp_carry = (vec[2] & vec[1]) | (vec[1] & vec[0]) | (vec[2] & vec[0]);
  assign mismatch  = (sum_in != exp_sum) || (carry_in != exp_carry);
  assign launch    = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_d = state;
    vec_d   = vec;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    err_d   = err_count;
    first_d = first_fail_vec;

    case (state)
      IDLE: ;
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) state_d = CHECK;
        else                                cnt_d   = cnt + 1'b1;
      end
      CHECK: begin
        // A vector with both outputs wrong still counts once.
        if (mismatch) begin
          err_d = err_count + 4'd1;
          if (err_count == 4'd0) first_d = vec;
        end
        if (vec != 3'd7) begin
          vec_d   = vec + 3'd1;
          cnt_d   = '0;
          state_d = AFTER_DRIVE;
        end else begin
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d = 1'b1;
        pass_d = (err_count == 4'd0);
      end
      default: state_d = IDLE;
    endcase

    // Restart from IDLE or DONE clears all previous results.
    if (launch) begin
      vec_d   = 3'd0;
      cnt_d   = '0;
      err_d   = 4'd0;
      first_d = 3'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      state_d = AFTER_DRIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= 3'd0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 4'd0;
      first_fail_vec <= 3'd0;
    end else begin
      state          <= state_d;
      vec            <= vec_d;
      cnt            <= cnt_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_fail_vec <= first_d;
    end
  end

endmodule

// File: tb/tb_fa_response_checker.sv
// Bench for fa_response_checker: two instances (settle 1 and settle 0) each beside a configurable adder model.
module tb_fa_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // adder model modes: 0 correct, 1 carry stuck-at-0, 2 sum inverted, 3 registered (1-clock latency)
  int mode1 = 0;
  int mode0 = 0;

  logic rst1, start1, a1, b1, c1, s1, k1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] ff1;
  logic rst0, start0, a0, b0, c0, s0, k0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [2:0] ff0;
  logic rs1, rc1, rs0, rc0;

  fa_response_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .c(c1),
    .sum_in(s1), .carry_in(k1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ff1)
  );

  fa_response_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .a(a0), .b(b0), .c(c0),
    .sum_in(s0), .carry_in(k0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ff0)
  );

  always @(posedge clk) begin
    rs1 <= a1 ^ b1 ^ c1;
    rc1 <= (a1 & b1) | (b1 & c1) | (a1 & c1);
    rs0 <= a0 ^ b0 ^ c0;
    rc0 <= (a0 & b0) | (b0 & c0) | (a0 & c0);
  end

  always_comb begin
    s1 = a1 ^ b1 ^ c1;
    k1 = (a1 & b1) | (b1 & c1) | (a1 & c1);
    case (mode1)
      1: k1 = 1'b0;
      2: s1 = ~(a1 ^ b1 ^ c1);
      3: begin s1 = rs1; k1 = rc1; end
      default: ;
    endcase
  end

  always_comb begin
    s0 = a0 ^ b0 ^ c0;
    k0 = (a0 & b0) | (b0 & c0) | (a0 & c0);
    case (mode0)
      1: k0 = 1'b0;
      2: s0 = ~(a0 ^ b0 ^ c0);
      3: begin s0 = rs0; k0 = rc0; end
      default: ;
    endcase
  end

  typedef struct {
    int err;
    int first;
    int pass;
    int lat;
    int busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // {sum,carry} of an ideal full adder
  function automatic logic [1:0] fa(input int v);
    logic [2:0] x;
    x = v[2:0];
    return {x[2] ^ x[1] ^ x[0], (x[2] & x[1]) | (x[1] & x[0]) | (x[2] & x[0])};
  endfunction

  function automatic exp_t model(input int s, input int mode, input int prev);
    exp_t e;
    logic [1:0] want, seen;
    e.err = 0;
    e.first = 0;
    for (int v = 0; v < 8; v++) begin
      want = fa(v);
      seen = want;
      if (mode == 1) seen = {want[1], 1'b0};
      if (mode == 2) seen = {~want[1], want[0]};
      if (mode == 3 && s == 0) seen = fa((v == 0) ? prev : v - 1);
      if (seen != want) begin
        if (e.err == 0) e.first = v;
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    e.lat  = 8 * (s + 1) + 1;
    e.busy = 8 * (s + 1);
    return e;
  endfunction

  task automatic do_reset(input int sel);
    @(negedge clk);
    if (sel == 1) rst1 = 1'b1; else rst0 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    rst0 = 1'b0;
  endtask

  // One complete run on the selected instance; mid_start>0 pulses start again while busy.
  task automatic run(input int sel, input int mode, input int mid_start, input string tag);
    exp_t e;
    int n, bc;
    if (sel == 1) mode1 = mode; else mode0 = mode;
    sb.push_back(model(sel, mode, 0));
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start0 = 1'b0;
    chk({tag, "_clr_err"}, sel == 1 ? err1 : err0, 0);
    chk({tag, "_clr_done"}, sel == 1 ? done1 : done0, 0);
    bc = (sel == 1 ? busy1 : busy0) ? 1 : 0;
    n = 0;
    while (n < 100) begin
      if (mid_start != 0 && n == mid_start) begin
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start1 = 1'b0;
        start0 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (sel == 1 ? busy1 : busy0) bc++;
      if (sel == 1 ? done1 : done0) break;
    end
    start1 = 1'b0;
    start0 = 1'b0;
    e = sb.pop_front();
    chk({tag, "_latency"}, n, e.lat);
    chk({tag, "_busy_clocks"}, bc, e.busy);
    chk({tag, "_err_count"}, sel == 1 ? err1 : err0, e.err);
    chk({tag, "_first_fail"}, sel == 1 ? ff1 : ff0, e.first);
    chk({tag, "_pass"}, sel == 1 ? pass1 : pass0, e.pass);
  endtask

  initial begin
    rst1 = 1'b0; rst0 = 1'b0; start1 = 1'b0; start0 = 1'b0;
    do_reset(1);
    do_reset(0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err", err1, 0);
    chk("rst_first", ff1, 0);
    chk("rst_abc", {a1, b1, c1}, 0);
    chk("rst0_done", done0, 0);

    run(1, 0, 0, "good");
    chk("done_abc", {a1, b1, c1}, 7);
    run(1, 1, 0, "carry_sa0");
    run(1, 2, 0, "sum_inv");
    run(1, 0, 0, "restart_from_done");

    // reset while vector 4 is on the adder inputs
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_vec", {a1, b1, c1}, 4);
    do_reset(1);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_abc", {a1, b1, c1}, 0);
    chk("mid_rst_err", err1, 0);
    run(1, 0, 0, "after_rst");

    run(1, 0, 4, "start_while_busy");

    run(0, 0, 0, "s0_good");
    do_reset(0);
    run(0, 3, 0, "s0_registered");
    run(1, 3, 0, "s1_registered");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
